// File: rtl/sockit_spi_wsp.sv
// Word splitter: takes BW-bit bus words and streams them MSB-chunk-first as
// DW-bit chunks over the CDC request/grant handshake.
module sockit_spi_wsp #(
    parameter int unsigned BW = 32,
    parameter int unsigned DW = 8,
    parameter int unsigned NW = 2,
    parameter int unsigned SW = 16
) (
    input  logic          cdi_clk,
    input  logic          cdi_rst,
    input  logic          bus_wen,
    input  logic [BW-1:0] bus_wdt,
    input  logic [NW-1:0] bus_len,
    input  logic          bus_abt,
    output logic          bus_rdy,
    output logic          sts_bsy,
    output logic [SW-1:0] sts_cnt,
    output logic          cdi_clr,
    output logic [DW-1:0] cdi_dat,
    output logic          cdi_req,
    input  logic          cdi_grt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state;
    logic [BW-1:0] shr;
    logic [NW-1:0] rem;
    logic          trn;
    logic          last;
    logic          acc;

    assign trn  = cdi_req & cdi_grt;
    assign last = (rem == '0);

    // Ready also while the final chunk transfers, so words stream without a bubble.
    assign bus_rdy = (state == IDLE) | ((state == SEND) & trn & last);
    assign acc     = bus_wen & bus_rdy & ~bus_abt;

    assign cdi_dat = shr[BW-1 -: DW];
    assign sts_bsy = (state == SEND);

    // Abort outranks accept and shift; a transfer sampled by the CDC is always counted.
    always_ff @(posedge cdi_clk or posedge cdi_rst) begin
        if (cdi_rst) begin
            state   <= IDLE;
            shr     <= '0;
            rem     <= '0;
            cdi_req <= 1'b0;
            cdi_clr <= 1'b0;
            sts_cnt <= '0;
        end else begin
            cdi_clr <= 1'b0;
            if (trn) begin
                sts_cnt <= sts_cnt + SW'(1);
            end
            if (bus_abt) begin
                state   <= IDLE;
                rem     <= '0;
                cdi_req <= 1'b0;
                cdi_clr <= 1'b1;
            end else if (acc) begin
                state   <= SEND;
                shr     <= bus_wdt;
                rem     <= bus_len;
                cdi_req <= 1'b1;
            end else if (trn) begin
                if (!last) begin
                    shr <= shr << DW;
                    rem <= rem - NW'(1);
                end else begin
                    state   <= IDLE;
                    cdi_req <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sockit_spi_wsp.sv
// Bench for sockit_spi_wsp: stimulus pushes expected chunks to a scoreboard,
// a negedge monitor pops and compares them as the CDC side consumes chunks.
module tb_sockit_spi_wsp;

    logic        cdi_clk;
    logic        cdi_rst;
    logic        bus_wen;
    logic [31:0] bus_wdt;
    logic [1:0]  bus_len;
    logic        bus_abt;
    logic        bus_rdy;
    logic        sts_bsy;
    logic [15:0] sts_cnt;
    logic        cdi_clr;
    logic [7:0]  cdi_dat;
    logic        cdi_req;
    logic        cdi_grt;

    sockit_spi_wsp #(.BW(32), .DW(8), .NW(2), .SW(16)) dut (
        .cdi_clk (cdi_clk),
        .cdi_rst (cdi_rst),
        .bus_wen (bus_wen),
        .bus_wdt (bus_wdt),
        .bus_len (bus_len),
        .bus_abt (bus_abt),
        .bus_rdy (bus_rdy),
        .sts_bsy (sts_bsy),
        .sts_cnt (sts_cnt),
        .cdi_clr (cdi_clr),
        .cdi_dat (cdi_dat),
        .cdi_req (cdi_req),
        .cdi_grt (cdi_grt)
    );

    initial cdi_clk = 1'b0;
    always #5 cdi_clk = ~cdi_clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  sb[$];
    int          m_left = 0;      // chunks of the current word not yet transferred
    logic [15:0] cnt_exp = '0;
    logic        clr_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: while a chunk is offered it must equal the scoreboard head; a grant consumes it.
    always @(negedge cdi_clk) begin
        if (!cdi_rst && cdi_req) begin
            if (sb.size() == 0) begin
                check("unexpected_chunk", {24'h0, cdi_dat}, 32'hFFFF_FFFF);
            end else begin
                check("cdi_dat", {24'h0, cdi_dat}, {24'h0, sb[0]});
                if (cdi_grt) void'(sb.pop_front());
            end
        end
    end

    // One clock cycle: called at posedge+1, drives inputs, advances the reference model.
    task automatic step(input logic wen, input logic [31:0] wdt, input logic [1:0] len,
                        input logic abt, input logic grt);
        bit trn, rdy, acc;
        int flush;
        bus_wen = wen;
        bus_wdt = wdt;
        bus_len = len;
        bus_abt = abt;
        cdi_grt = grt;
        trn = (m_left != 0) && grt;
        rdy = (m_left == 0) || (trn && m_left == 1);
        acc = wen && rdy && !abt;
        #1;
        check("bus_rdy", {31'h0, bus_rdy}, {31'h0, rdy});
        flush = 0;
        if (trn) begin
            m_left--;
            cnt_exp++;
        end
        if (abt) begin
            flush  = m_left;
            m_left = 0;
        end else if (acc) begin
            for (int i = 0; i <= int'(len); i++) sb.push_back(wdt[31-8*i -: 8]);
            m_left = int'(len) + 1;
        end
        clr_exp = abt;
        @(posedge cdi_clk);
        for (int i = 0; i < flush; i++) void'(sb.pop_back());
        #1;
        check("cdi_req", {31'h0, cdi_req}, {31'h0, (m_left != 0)});
        check("sts_bsy", {31'h0, sts_bsy}, {31'h0, (m_left != 0)});
        check("cdi_clr", {31'h0, cdi_clr}, {31'h0, clr_exp});
        check("sts_cnt", {16'h0, sts_cnt}, {16'h0, cnt_exp});
    endtask

    task automatic idle(input int n, input logic grt);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 2'd0, 1'b0, grt);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, {31'h0, cdi_req}, 32'h0);
        check({tag, "_dat"}, {24'h0, cdi_dat}, 32'h0);
        check({tag, "_clr"}, {31'h0, cdi_clr}, 32'h0);
        check({tag, "_cnt"}, {16'h0, sts_cnt}, 32'h0);
        check({tag, "_bsy"}, {31'h0, sts_bsy}, 32'h0);
        check({tag, "_rdy"}, {31'h0, bus_rdy}, 32'h1);
    endtask

    initial begin
        cdi_rst = 1'b1;
        bus_wen = 1'b0;
        bus_wdt = '0;
        bus_len = '0;
        bus_abt = 1'b0;
        cdi_grt = 1'b0;
        repeat (2) @(posedge cdi_clk);
        #1;
        check_reset_values("reset");
        cdi_rst = 1'b0;

        // Single word with continuous grant, then a back-to-back word on the last chunk.
        step(1'b1, 32'hA1B2C3D4, 2'd3, 1'b0, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 32'h11223344, 2'd1, 1'b0, 1'b1);
        idle(3, 1'b1);
        check("cnt_after_b2b", {16'h0, sts_cnt}, 32'd6);

        // Grant stall with ignored writes.
        step(1'b1, 32'hA1B2C3D4, 2'd3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0);
        idle(5, 1'b1);

        // Short word.
        step(1'b1, 32'hA1B2C3D4, 2'd0, 1'b0, 1'b1);
        idle(2, 1'b1);
        check("cnt_after_short", {16'h0, sts_cnt}, 32'd11);

        // Abort after two chunks, abort with write in idle, abort with a transfer.
        step(1'b1, 32'hA1B2C3D4, 2'd3, 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        check("cnt_after_abort", {16'h0, sts_cnt}, 32'd13);
        step(1'b1, 32'h55667788, 2'd3, 1'b1, 1'b1);
        idle(1, 1'b1);
        step(1'b1, 32'h99AABBCC, 2'd2, 1'b0, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
        idle(2, 1'b1);
        check("cnt_after_abort_trn", {16'h0, sts_cnt}, 32'd14);

        // Asynchronous reset mid-word.
        step(1'b1, 32'hA1B2C3D4, 2'd3, 1'b0, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
        #2;
        cdi_rst = 1'b1;
        bus_wen = 1'b0;
        cdi_grt = 1'b0;
        #1;
        check_reset_values("async_reset");
        sb.delete();
        m_left  = 0;
        cnt_exp = '0;
        @(posedge cdi_clk);
        #1;
        cdi_rst = 1'b0;

        // Stream 65536 chunks to wrap the counter back to zero.
        step(1'b1, $urandom, 2'd3, 1'b0, 1'b1);
        for (int w = 1; w < 16384; w++) begin
            idle(3, 1'b1);
            step(1'b1, $urandom, 2'd3, 1'b0, 1'b1);
        end
        idle(3, 1'b1);
        check("cnt_at_ffff", {16'h0, sts_cnt}, 32'hFFFF);
        idle(1, 1'b1);
        check("cnt_wrap", {16'h0, sts_cnt}, 32'h0);
        idle(1, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
        end
        idle(6, 1'b1);
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sockit_spi_wsp.md
# sockit_spi_wsp

Word splitter in the `cdi_clk` domain, directly upstream of the SPI clock-domain-crossing stage. It accepts whole bus words from the register interface and emits them as a stream of `DW`-bit chunks, MSB chunk first. The output uses the CDC input port's request/grant handshake (`cdi_req`/`cdi_grt`, `cdi_dat`, `cdi_clr`), so the block drives the CDC input directly with no glue.

## Interface
Parameters:
- `BW`, 32 — bus word width; must be an integer multiple of `DW`.
- `DW`, 8 — chunk width; matches the CDC `DW`.
- `NW`, 2 — width of `bus_len`; equals log2(`BW`/`DW`).
- `SW`, 16 — width of the status chunk counter.

Ports:
- `cdi_clk` in 1 — clock.
- `cdi_rst` in 1 — reset: asynchronous, active-high.
- `bus_wen` in 1 — word write strobe.
- `bus_wdt` in `BW` — word data.
- `bus_len` in `NW` — number of chunks minus one.
- `bus_abt` in 1 — abort strobe.
- `bus_rdy` out 1 — block can accept a word this cycle.
- `sts_bsy` out 1 — a word is in progress.
- `sts_cnt` out `SW` — count of chunks transferred; wraps.
- `cdi_clr` out 1 — clear pulse to the CDC.
- `cdi_dat` out `DW` — chunk data.
- `cdi_req` out 1 — chunk valid (request).
- `cdi_grt` in 1 — CDC grant.

## Operation
- The block has two states, IDLE and SEND. It holds a shift register `shr` of `BW` bits and a remaining-chunk counter `rem` of `NW` bits.
- Transfer definition: `trn = cdi_req & cdi_grt`.
- **Accepting a word:**
  - `bus_rdy = IDLE | (SEND & trn & rem==0)`. This is combinational from `cdi_grt`, which allows back-to-back words without a bubble.
  - A word is accepted when `bus_wen & bus_rdy & ~bus_abt`.
  - On accept: `shr <= bus_wdt`, `rem <= bus_len`, state becomes SEND, `cdi_req <= 1`.
- **Chunk output:**
  - `cdi_dat = shr[BW-1 -: DW]`. Chunk i of a word is `bus_wdt[BW-1-i*DW -: DW]`.
  - In SEND with `trn` and `rem != 0`: `shr <= shr << DW`, `rem <= rem-1`, `cdi_req` stays 1.
  - In SEND with `trn` and `rem == 0`: if a word is accepted in the same cycle, load it. Otherwise state becomes IDLE and `cdi_req <= 0`.
- **Handshake rules:**
  - Once asserted, `cdi_req` is never deasserted without `trn`, except on abort or reset.
  - `cdi_dat` is held stable while `cdi_req & ~cdi_grt`.
  - `bus_wen` while `~bus_rdy` is ignored; no error is flagged.
- **Abort:**
  - `bus_abt` has priority over every other event: state becomes IDLE, `cdi_req <= 0`, `rem <= 0`, `cdi_clr <= 1` for exactly one cycle.
  - A `bus_wen` coinciding with `bus_abt` is dropped.
  - A `trn` coinciding with `bus_abt` still counts in `sts_cnt`, since the CDC sampled it.
  - Abort in IDLE still pulses `cdi_clr`.
- **Status:**
  - `sts_cnt` increments by 1 on every `trn` and wraps from 2^SW-1 to 0. It is not cleared by abort.
  - `sts_bsy` = (state == SEND).

## Timing
- **Reset values:** state IDLE, `cdi_req` 0, `cdi_dat` 0 (`shr` cleared), `cdi_clr` 0, `sts_cnt` 0, `sts_bsy` 0, `bus_rdy` 1.
- **Latency:** a word accepted at clock edge k gives `cdi_req`=1 with chunk 0 on `cdi_dat` after edge k.
- **Throughput:** with `cdi_grt` held at 1, a word of L+1 chunks occupies L+1 cycles, and consecutive words stream with no idle cycle.
- **Abort:** `bus_abt` sampled at edge k gives `cdi_clr`=1 and `cdi_req`=0 during cycle k..k+1, and `cdi_clr`=0 after edge k+1.
- **Reset mid-word:** `cdi_rst` asserted mid-word returns all outputs to reset values immediately (asynchronous), with no `cdi_clr` pulse.
- All outputs except `bus_rdy` are registered.

## Test plan
- **Single word, continuous grant:** `bus_wdt`=32'hA1B2C3D4, `bus_len`=3, `cdi_grt`=1 → `cdi_dat` is A1, B2, C3, D4 on 4 consecutive cycles; then `cdi_req`=0, `sts_cnt`=4.
- **Back-to-back words:** second word 32'h11223344 with `bus_len`=1 written in the cycle D4 transfers → 11, 22 follow with no gap; `sts_cnt`=6.
- **Grant stall:** `cdi_grt`=0 for 5 cycles after accept → `cdi_req`=1 and `cdi_dat`=A1 stable throughout; `bus_rdy`=0 and writes ignored.
- **Short word:** `bus_len`=0 → only A1 is sent, then IDLE.
- **Abort mid-word:** abort after 2 chunks → one-cycle `cdi_clr`, `cdi_req`=0, `sts_cnt`=2.
  - Abort coincident with `bus_wen` → word dropped.
  - Abort coincident with `trn` → that chunk is counted.
- **Reset and wrap:** async reset mid-word → all reset values immediately. Preload the counter to 16'hFFFF via transfers and perform one more `trn` → `sts_cnt`=0.
